// File: rtl/key_click_decoder_if.sv
// Key click decoder bus: the debounced press pulse going in, the
// click classification pulses, the held code and busy coming out.
interface key_click_decoder_if;
    logic       key_flag;
    logic       single_flag;
    logic       double_flag;
    logic       triple_flag;
    logic [1:0] last_click;
    logic       busy;

    // Upstream side: the debounce stage drives presses, mode logic reads results
    modport master (
        output key_flag,
        input  single_flag,
        input  double_flag,
        input  triple_flag,
        input  last_click,
        input  busy
    );

    // Decoder side
    modport slave (
        input  key_flag,
        output single_flag,
        output double_flag,
        output triple_flag,
        output last_click,
        output busy
    );
endinterface

// File: rtl/key_click_decoder.sv
// Key click decoder: groups debounced presses into bursts separated by an
// inter-press window of WINDOW_MAX+1 cycles and classifies each burst as a
// single, double or triple click. A third press ends the burst at once;
// one or two presses are classified when the window after the last press
// runs out. A press landing on the final window cycle still counts as part
// of the burst.
module key_click_decoder #(
    parameter int               CNT_W      = 25,
    parameter logic [CNT_W-1:0] WINDOW_MAX = 25'd24_999_999
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    key_click_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             window_done;

    assign window_done = (timer == WINDOW_MAX);

    // Burst FSM, window timer and all registered outputs; busy mirrors next state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state           <= IDLE;
            timer           <= '0;
            bus.single_flag <= 1'b0;
            bus.double_flag <= 1'b0;
            bus.triple_flag <= 1'b0;
            bus.last_click  <= 2'd0;
            bus.busy        <= 1'b0;
        end else begin
            bus.single_flag <= 1'b0;
            bus.double_flag <= 1'b0;
            bus.triple_flag <= 1'b0;

            case (state)
                IDLE: begin
                    timer <= '0;
                    if (bus.key_flag) begin
                        state    <= WAIT1;
                        bus.busy <= 1'b1;
                    end else begin
                        bus.busy <= 1'b0;
                    end
                end

                WAIT1: begin
                    if (bus.key_flag) begin
                        state    <= WAIT2;
                        timer    <= '0;
                        bus.busy <= 1'b1;
                    end else if (window_done) begin
                        state           <= IDLE;
                        timer           <= '0;
                        bus.single_flag <= 1'b1;
                        bus.last_click  <= 2'd1;
                        bus.busy        <= 1'b0;
                    end else begin
                        timer    <= timer + 1'b1;
                        bus.busy <= 1'b1;
                    end
                end

                WAIT2: begin
                    if (bus.key_flag) begin
                        state           <= IDLE;
                        timer           <= '0;
                        bus.triple_flag <= 1'b1;
                        bus.last_click  <= 2'd3;
                        bus.busy        <= 1'b0;
                    end else if (window_done) begin
                        state           <= IDLE;
                        timer           <= '0;
                        bus.double_flag <= 1'b1;
                        bus.last_click  <= 2'd2;
                        bus.busy        <= 1'b0;
                    end else begin
                        timer    <= timer + 1'b1;
                        bus.busy <= 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    timer    <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_click_decoder.sv
// Testbench for key_click_decoder with a 100-cycle window (WINDOW_MAX = 99).
// Expected classification pulses are queued when the presses are driven and
// popped by a monitor as the decoder emits them; each scenario task also
// checks busy and last_click cycle by cycle against the expected timeline.
module tb_key_click_decoder;

    localparam int               CNT_W = 25;
    localparam int               WIN   = 99;
    localparam logic [CNT_W-1:0] WMAX  = 25'd99;

    typedef struct {
        int         cycle;
        logic [1:0] kind;
    } exp_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    int   cyc         = 0;
    int   t0          = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    key_click_decoder_if bus();

    key_click_decoder #(
        .CNT_W      (CNT_W),
        .WINDOW_MAX (WMAX)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    // 50 MHz clock
    always #10 sys_clk = ~sys_clk;

    // Free-running cycle counter; scenarios measure relative to t0
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Scoreboard monitor: every pulse must match the head of the queue
    always @(negedge sys_clk) begin
        automatic int         rel    = cyc - t0;
        automatic int         npulse = 0;
        automatic logic [1:0] obs    = 2'd0;
        automatic exp_t       e;
        if (bus.single_flag === 1'b1) begin npulse++; obs = 2'd1; end
        if (bus.double_flag === 1'b1) begin npulse++; obs = 2'd2; end
        if (bus.triple_flag === 1'b1) begin npulse++; obs = 2'd3; end
        if (sb.size() > 0 && sb[0].cycle < rel) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL missed_pulse: kind %0d expected at cycle %0d, not observed by cycle %0d",
                     sb[0].kind, sb[0].cycle, rel);
            void'(sb.pop_front());
        end
        if (npulse > 1) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL one_hot: %0d pulses high at cycle %0d, at most 1 allowed", npulse, rel);
        end
        if (obs != 2'd0) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_pulse: kind %0d at cycle %0d, none expected", obs, rel);
            end else begin
                e = sb.pop_front();
                if (e.cycle != rel || e.kind !== obs) begin
                    miscompares++;
                    $display("[TB] FAIL pulse: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                             obs, rel, e.kind, e.cycle);
                end
            end
        end
    end

    // Hold reset a few cycles, release, and restart the relative cycle count
    task automatic do_reset();
        bus.key_flag = 1'b0;
        sys_rst_n    = 1'b0;
        sb.delete();
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1 t0 = cyc;
    endtask

    task automatic test_reset();
        bus.key_flag = 1'b0;
        sys_rst_n    = 1'b0;
        sb.delete();
        @(negedge sys_clk);
        vectors++;
        if ({bus.single_flag, bus.double_flag, bus.triple_flag, bus.last_click, bus.busy} !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got %b, expected 000000",
                     {bus.single_flag, bus.double_flag, bus.triple_flag, bus.last_click, bus.busy});
        end
        do_reset();
        for (int c = 1; c <= 500; c++) begin
            @(posedge sys_clk);
            #1 bus.key_flag = 1'b0;
            @(negedge sys_clk);
            vectors++;
            if ({bus.single_flag, bus.double_flag, bus.triple_flag, bus.last_click, bus.busy} !== 6'd0) begin
                miscompares++;
                $display("[TB] FAIL idle_outputs: cycle %0d got %b, expected 000000", c,
                         {bus.single_flag, bus.double_flag, bus.triple_flag, bus.last_click, bus.busy});
            end
        end
    endtask

    task automatic test_single();
        logic       exp_busy;
        logic [1:0] exp_last;
        do_reset();
        for (int c = 1; c <= 150; c++) begin
            @(posedge sys_clk);
            #1 bus.key_flag = (c == 10);
            if (c == 10) sb.push_back('{cycle: c + WIN + 2, kind: 2'd1});
            @(negedge sys_clk);
            exp_busy = (c >= 11 && c <= 110);
            exp_last = (c >= 111) ? 2'd1 : 2'd0;
            vectors++;
            if (bus.busy !== exp_busy) begin
                miscompares++;
                $display("[TB] FAIL single_busy: cycle %0d got %b, expected %b", c, bus.busy, exp_busy);
            end
            vectors++;
            if (bus.last_click !== exp_last) begin
                miscompares++;
                $display("[TB] FAIL single_last: cycle %0d got %0d, expected %0d", c, bus.last_click, exp_last);
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL single_pending: %0d pulses outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_double();
        logic       exp_busy;
        logic [1:0] exp_last;
        do_reset();
        for (int c = 1; c <= 180; c++) begin
            @(posedge sys_clk);
            #1 bus.key_flag = (c == 10 || c == 60);
            if (c == 60) sb.push_back('{cycle: c + WIN + 2, kind: 2'd2});
            @(negedge sys_clk);
            exp_busy = (c >= 11 && c <= 160);
            exp_last = (c >= 161) ? 2'd2 : 2'd0;
            vectors++;
            if (bus.busy !== exp_busy) begin
                miscompares++;
                $display("[TB] FAIL double_busy: cycle %0d got %b, expected %b", c, bus.busy, exp_busy);
            end
            vectors++;
            if (bus.last_click !== exp_last) begin
                miscompares++;
                $display("[TB] FAIL double_last: cycle %0d got %0d, expected %0d", c, bus.last_click, exp_last);
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL double_pending: %0d pulses outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_triple();
        logic       exp_busy;
        logic [1:0] exp_last;
        do_reset();
        for (int c = 1; c <= 220; c++) begin
            @(posedge sys_clk);
            #1 bus.key_flag = (c == 10 || c == 50 || c == 90);
            if (c == 90) sb.push_back('{cycle: c + 1, kind: 2'd3});
            @(negedge sys_clk);
            exp_busy = (c >= 11 && c <= 90);
            exp_last = (c >= 91) ? 2'd3 : 2'd0;
            vectors++;
            if (bus.busy !== exp_busy) begin
                miscompares++;
                $display("[TB] FAIL triple_busy: cycle %0d got %b, expected %b", c, bus.busy, exp_busy);
            end
            vectors++;
            if (bus.last_click !== exp_last) begin
                miscompares++;
                $display("[TB] FAIL triple_last: cycle %0d got %0d, expected %0d", c, bus.last_click, exp_last);
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL triple_pending: %0d pulses outstanding, expected 0", sb.size());
        end
    endtask

    // Second press on the last window cycle: the press wins over the timeout
    task automatic test_window_tie();
        logic       exp_busy;
        logic [1:0] exp_last;
        do_reset();
        for (int c = 1; c <= 230; c++) begin
            @(posedge sys_clk);
            #1 bus.key_flag = (c == 10 || c == 10 + WIN + 1);
            if (c == 10 + WIN + 1) sb.push_back('{cycle: c + WIN + 2, kind: 2'd2});
            @(negedge sys_clk);
            exp_busy = (c >= 11 && c <= 210);
            exp_last = (c >= 211) ? 2'd2 : 2'd0;
            vectors++;
            if (bus.busy !== exp_busy) begin
                miscompares++;
                $display("[TB] FAIL tie_busy: cycle %0d got %b, expected %b", c, bus.busy, exp_busy);
            end
            vectors++;
            if (bus.last_click !== exp_last) begin
                miscompares++;
                $display("[TB] FAIL tie_last: cycle %0d got %0d, expected %0d", c, bus.last_click, exp_last);
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL tie_pending: %0d pulses outstanding, expected 0", sb.size());
        end
    endtask

    // Second press one cycle past the window lands with the single pulse
    task automatic test_back_to_back();
        logic       exp_busy;
        logic [1:0] exp_last;
        do_reset();
        for (int c = 1; c <= 230; c++) begin
            @(posedge sys_clk);
            #1 bus.key_flag = (c == 10 || c == 10 + WIN + 2);
            if (c == 10 || c == 10 + WIN + 2) sb.push_back('{cycle: c + WIN + 2, kind: 2'd1});
            @(negedge sys_clk);
            exp_busy = (c >= 11 && c <= 110) || (c >= 112 && c <= 211);
            exp_last = (c >= 111) ? 2'd1 : 2'd0;
            vectors++;
            if (bus.busy !== exp_busy) begin
                miscompares++;
                $display("[TB] FAIL b2b_busy: cycle %0d got %b, expected %b", c, bus.busy, exp_busy);
            end
            vectors++;
            if (bus.last_click !== exp_last) begin
                miscompares++;
                $display("[TB] FAIL b2b_last: cycle %0d got %0d, expected %0d", c, bus.last_click, exp_last);
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_pending: %0d pulses outstanding, expected 0", sb.size());
        end
    endtask

    // Completed single, then a burst killed by reset, then a fresh single
    task automatic test_reset_mid_burst();
        logic       exp_busy;
        logic [1:0] exp_last;
        do_reset();
        for (int c = 1; c <= 370; c++) begin
            @(posedge sys_clk);
            #1;
            bus.key_flag = (c == 10 || c == 150 || c == 250);
            sys_rst_n    = !(c >= 180 && c <= 182);
            if (c == 10 || c == 250) sb.push_back('{cycle: c + WIN + 2, kind: 2'd1});
            @(negedge sys_clk);
            exp_busy = (c >= 11 && c <= 110) || (c >= 151 && c <= 179) || (c >= 251 && c <= 350);
            exp_last = ((c >= 111 && c <= 179) || c >= 351) ? 2'd1 : 2'd0;
            vectors++;
            if (bus.busy !== exp_busy) begin
                miscompares++;
                $display("[TB] FAIL rst_busy: cycle %0d got %b, expected %b", c, bus.busy, exp_busy);
            end
            vectors++;
            if (bus.last_click !== exp_last) begin
                miscompares++;
                $display("[TB] FAIL rst_last: cycle %0d got %0d, expected %0d", c, bus.last_click, exp_last);
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL rst_pending: %0d pulses outstanding, expected 0", sb.size());
        end
    endtask

    initial begin
        bus.key_flag = 1'b0;
        test_reset();
        test_single();
        test_double();
        test_triple();
        test_window_tie();
        test_back_to_back();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_click_decoder.md
Name: key_click_decoder

Overview:
- Sits directly downstream of the key debounce stage.
- Consumes its one-cycle debounced press pulse (key_flag) and classifies each burst of presses as a single, double or triple click, using an inter-press time window.
- Emits one-cycle classification pulses and a held "last click" code for mode-control logic (LED/mode FSMs).

Parameters:
- WINDOW_MAX, 25'd24_999_999, last timer value of the inter-press window: 500 ms at 50 MHz. The window is WINDOW_MAX+1 cycles.
- CNT_W, 25, timer width. Must hold WINDOW_MAX.

Ports:
- sys_clk  input  1  system clock, 50 MHz
- sys_rst_n  input  1  asynchronous active-low reset
- key_flag  input  1  debounced press pulse; one cycle high per press, synchronous to sys_clk
- single_flag  output  1  one-cycle pulse: burst classified as 1 click
- double_flag  output  1  one-cycle pulse: burst classified as 2 clicks
- triple_flag  output  1  one-cycle pulse: burst classified as 3 clicks
- last_click  output  2  held code of most recent classification: 0 none, 1 single, 2 double, 3 triple
- busy  output  1  high while a burst is being timed (state != IDLE)

Behaviour:
- One clock: sys_clk. Asynchronous active-low reset: sys_rst_n. All state and outputs are registered.
- Reset values: state IDLE, timer 0, single_flag/double_flag/triple_flag 0, last_click 2'd0, busy 0.
- FSM states: IDLE, WAIT1 (one press seen), WAIT2 (two presses seen).
- Timer:
  - Cleared to 0 on every accepted key_flag.
  - In WAIT1/WAIT2 it increments by 1 per cycle and saturates at WINDOW_MAX.
  - In IDLE it is held at 0.
- Timeout condition: state is WAIT1 or WAIT2, timer == WINDOW_MAX, and key_flag == 0.
- Transitions:
  - IDLE, key_flag=1 -> WAIT1, timer <= 0.
  - WAIT1, key_flag=1 -> WAIT2, timer <= 0.
  - WAIT1, timeout -> IDLE; single_flag <= 1; last_click <= 1.
  - WAIT2, key_flag=1 -> IDLE; triple_flag <= 1; last_click <= 3. Triple is issued immediately; no waiting for the window.
  - WAIT2, timeout -> IDLE; double_flag <= 1; last_click <= 2.
  - Otherwise hold state.
- Simultaneous key_flag and timeout in the same cycle: key_flag wins. It counts as a further press and no timeout pulse is issued.
- Latency, with key_flag high in cycle T:
  - Single or double click (T = cycle of the last press): pulse high in cycle T+WINDOW_MAX+2.
  - Triple click (T = cycle of the 3rd press): triple_flag high in cycle T+1.
- Output pulses:
  - Each pulse is exactly one cycle wide.
  - At most one of the three pulses is high in any cycle.
  - All three default to 0 every cycle unless set.
- last_click changes only in the cycle its pulse is set and holds otherwise.
- busy = registered (next_state != IDLE). It rises in cycle T+1 after the first press and falls in the same cycle the classification pulse is high.
- key_flag arriving in IDLE in the same cycle a classification pulse is high: accepted normally and starts a new burst. busy is high the next cycle.
- key_flag held high more than one cycle violates the input contract. Each high cycle counts as a press; no protection is provided.
- Reset asserted mid-burst: everything clears immediately and asynchronously, and no classification pulse is emitted. last_click returns to 0. The first key_flag after reset release starts a fresh burst.
- No arithmetic wrap: the timer saturates at WINDOW_MAX and never exceeds it.

Test Plan:
- Reset / idle check (WINDOW_MAX=99): apply reset, then idle for 500 cycles with no key_flag -> all pulses 0, last_click 0, busy 0 throughout.
- Single click: one key_flag pulse at cycle 10 -> busy high cycles 11..110, single_flag high only in cycle 111, last_click=1 from cycle 111 on.
- Double click: key_flag at cycles 10 and 60 -> double_flag high only in cycle 161, last_click=2, no single_flag.
- Triple click: key_flag at cycles 10, 50, 90 -> triple_flag high only in cycle 91, busy low from cycle 91, last_click=3.
- Window boundary and tie, single/double boundary:
  - Second key_flag exactly 100 cycles after the first (timer == WINDOW_MAX, tie rule) -> double_flag later, never single_flag.
  - Second key_flag 101 cycles after the first -> single_flag at the first's +101, then a new burst starts.
- Reset mid-burst: key_flag at cycle 10, reset asserted cycles 40..42, no further presses -> no pulse ever, busy 0 from cycle 40, last_click 0.
